// File: rtl/pixel_drain.sv
// pixel_drain
//   Receive-side master that pulls one frame over a req/ack pixel handshake,
//   buffers the pixels in a small FIFO and presents them on a valid/ready
//   stream tagged with start-of-frame, end-of-line and end-of-frame markers.
//   A 32-bit checksum of the accepted pixels is accumulated, and done pulses
//   for one cycle once the final pixel has left the FIFO.
//
// Ports
//   clk        clock
//   xrst       synchronous active-low reset
//   start      one-cycle pulse that begins a frame pull (honoured only in IDLE)
//   pixel_in   24-bit RGB pixel from the responder
//   rcv_req    pixel request to the responder
//   rcv_ack    responder ack; a pixel transfers on rcv_req && rcv_ack
//   out_pixel  FIFO head pixel
//   out_sof    head is pixel (0,0)
//   out_eol    head is the last pixel of a line
//   out_eof    head is the last pixel of the frame
//   out_valid  FIFO not empty
//   out_ready  sink accepts the head on out_valid && out_ready
//   busy       a frame pull is in progress
//   done       one-cycle pulse when the frame has fully drained
//   checksum   sum mod 2^32 of {8'h0,pixel} over accepted pixels

module pixel_drain #(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        xrst,
  input  logic        start,
  input  logic [23:0] pixel_in,
  output logic        rcv_req,
  input  logic        rcv_ack,
  output logic [23:0] out_pixel,
  output logic        out_sof,
  output logic        out_eol,
  output logic        out_eof,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] checksum
);

  localparam int XW    = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int TOTAL = WIDTH * HEIGHT;
  localparam int CW    = $clog2(TOTAL);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int EW    = 27;

  localparam logic [XW-1:0] X_LAST    = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST    = YW'(HEIGHT - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(TOTAL - 1);
  localparam logic [AW:0]   FILL_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   FILL_ONE  = (AW+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t          state;
  state_t          state_next;

  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic [CW-1:0]   count;
  logic [31:0]     sum;

  logic [EW-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     fill;
  logic [EW-1:0]   head;

  logic            push;
  logic            pop;
  logic            last_px;
  logic            sof_in;
  logic            eol_in;

  // Request is purely registered state, so the responder never sees a
  // combinational path from its own ack back into req.
  assign rcv_req   = (state == S_RUN) && (fill < FILL_FULL);
  assign push      = rcv_req && rcv_ack;
  assign out_valid = (fill != '0);
  assign pop       = out_valid && out_ready;

  assign last_px = (count == CNT_LAST);
  assign sof_in  = (x == '0) && (y == '0);
  assign eol_in  = (x == X_LAST);

  // The storage array is not reset, so the head is masked while empty to
  // keep the stream outputs at zero after reset.
  assign head      = mem[rd_ptr];
  assign out_pixel = out_valid ? head[26:3] : '0;
  assign out_sof   = out_valid && head[2];
  assign out_eol   = out_valid && head[1];
  assign out_eof   = out_valid && head[0];

  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);
  assign checksum = sum;

  always_ff @(posedge clk) begin
    if (!xrst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FLUSH leaves on the edge that pops the last entry, so done follows the
  // final pop by one cycle.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (push && last_px) begin
          state_next = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if ((fill == '0) || ((fill == FILL_ONE) && pop)) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Position counters and checksum; cleared when a new frame starts so the
  // checksum of the previous frame stays visible until then.
  always_ff @(posedge clk) begin
    if (!xrst) begin
      x     <= '0;
      y     <= '0;
      count <= '0;
      sum   <= '0;
    end else if ((state == S_IDLE) && start) begin
      x     <= '0;
      y     <= '0;
      count <= '0;
      sum   <= '0;
    end else if (push) begin
      sum <= sum + {8'h00, pixel_in};
      if (!last_px) begin
        count <= count + 1'b1;
      end
      if (x == X_LAST) begin
        x <= '0;
        y <= (y == Y_LAST) ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {pixel_in, sof_in, eol_in, last_px};
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (!xrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_drain.sv
// tb_pixel_drain
//   Self-checking bench for pixel_drain. The main instance runs a 4x2 frame
//   with a 4-entry FIFO; a second instance covers the 2x1 frame geometry.
//   Expected stream entries are queued as pixels are handed to the design
//   and a negedge monitor pops and compares them as the design emits them.

module tb_pixel_drain;

  localparam int W    = 4;
  localparam int H    = 2;
  localparam int D    = 4;
  localparam int NPIX = W * H;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        xrst;
  logic        start;
  logic [23:0] pixel_in;
  logic        rcv_req;
  logic        rcv_ack;
  logic [23:0] out_pixel;
  logic        out_sof;
  logic        out_eol;
  logic        out_eof;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;
  logic [31:0] checksum;

  logic        start2;
  logic [23:0] pixel_in2;
  logic        rcv_req2;
  logic        rcv_ack2;
  logic [23:0] out_pixel2;
  logic        out_sof2;
  logic        out_eol2;
  logic        out_eof2;
  logic        out_valid2;
  logic        out_ready2;
  logic        busy2;
  logic        done2;
  logic [31:0] checksum2;

  int          vec_cnt = 0;
  int          err_cnt = 0;
  int          pix_idx = 0;
  int          xfers = 0;
  int          pops = 0;
  int          done_cnt = 0;
  int          ack_mode = 2;
  int          ready_mode = 2;
  bit          poke_start = 1'b0;
  logic        xfer_seen = 1'b0;
  logic [23:0] frame_px [NPIX];
  logic [26:0] exp_q [$];

  pixel_drain #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(D)) u_dut (
    .clk       (clk),
    .xrst      (xrst),
    .start     (start),
    .pixel_in  (pixel_in),
    .rcv_req   (rcv_req),
    .rcv_ack   (rcv_ack),
    .out_pixel (out_pixel),
    .out_sof   (out_sof),
    .out_eol   (out_eol),
    .out_eof   (out_eof),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .checksum  (checksum)
  );

  pixel_drain #(.WIDTH(2), .HEIGHT(1), .FIFO_DEPTH(4)) u_dut2 (
    .clk       (clk),
    .xrst      (xrst),
    .start     (start2),
    .pixel_in  (pixel_in2),
    .rcv_req   (rcv_req2),
    .rcv_ack   (rcv_ack2),
    .out_pixel (out_pixel2),
    .out_sof   (out_sof2),
    .out_eol   (out_eol2),
    .out_eof   (out_eof2),
    .out_valid (out_valid2),
    .out_ready (out_ready2),
    .busy      (busy2),
    .done      (done2),
    .checksum  (checksum2)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected stream entry for frame pixel k of a W x H frame.
  function automatic logic [26:0] exp_entry(input int k);
    logic sof;
    logic eol;
    logic eof;
    sof = (k == 0);
    eol = ((k % W) == (W - 1));
    eof = (k == (NPIX - 1));
    return {frame_px[k], sof, eol, eof};
  endfunction

  // One clock: record the transfer that happened on this edge, then drive
  // the next cycle's responder and sink inputs.
  task automatic tick();
    @(posedge clk);
    #1;
    start = 1'b0;
    if (xfer_seen) begin
      if (pix_idx < NPIX) begin
        exp_q.push_back(exp_entry(pix_idx));
      end
      pix_idx++;
      xfers++;
    end
    pixel_in = (pix_idx < NPIX) ? frame_px[pix_idx] : 24'h0;
    case (ack_mode)
      0:       rcv_ack = 1'b1;
      1:       rcv_ack = ~rcv_ack;
      default: rcv_ack = 1'b0;
    endcase
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
    if (poke_start && busy) begin
      start = 1'b1;
    end
  endtask

  // Monitor: decide transfers and compare the stream head away from the edge.
  always @(negedge clk) begin
    xfer_seen = xrst && rcv_req && rcv_ack;
    if (xrst) begin
      if (out_valid && out_ready) begin
        checkOutput("sb_has_entry", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          checkOutput("stream_head", 64'({out_pixel, out_sof, out_eol, out_eof}),
                      64'(exp_q.pop_front()));
        end
        pops++;
      end
      if (done) begin
        done_cnt++;
        checkOutput("pops_at_done", 64'(pops), 64'(NPIX));
      end
    end
  end

  // Pull one full frame. stall > 0 holds out_ready low for that many cycles
  // first; max_cyc > 0 bounds the cycles from start to the done pulse.
  task automatic applyStimulus(input int ackm, input int readym, input int stall,
                               input bit poke, input logic [31:0] exp_sum, input int max_cyc);
    int cyc;
    pix_idx  = 0;
    xfers    = 0;
    pops     = 0;
    done_cnt = 0;
    exp_q.delete();
    ack_mode   = ackm;
    ready_mode = (stall > 0) ? 2 : readym;
    poke_start = 1'b0;
    rcv_ack    = 1'b1;
    out_ready  = (ready_mode != 2);
    pixel_in   = frame_px[0];
    start      = 1'b1;
    tick();
    checkOutput("busy_after_start", 64'(busy), 64'd1);
    if (stall > 0) begin
      repeat (stall) tick();
      checkOutput("stall_xfers", 64'(xfers), 64'(D));
      checkOutput("stall_req", 64'(rcv_req), 64'd0);
      checkOutput("stall_valid", 64'(out_valid), 64'd1);
      checkOutput("stall_head", 64'(out_pixel), 64'(frame_px[0]));
      ready_mode = readym;
    end
    poke_start = poke;
    cyc = 0;
    while (done_cnt == 0 && cyc < 200) begin
      tick();
      cyc++;
    end
    poke_start = 1'b0;
    checkOutput("done_seen", 64'(done_cnt > 0), 64'd1);
    if (max_cyc > 0) begin
      checkOutput("done_latency_ok", 64'(cyc <= max_cyc), 64'd1);
    end
    repeat (3) tick();
    checkOutput("done_once", 64'(done_cnt), 64'd1);
    checkOutput("xfer_count", 64'(xfers), 64'(NPIX));
    checkOutput("pop_count", 64'(pops), 64'(NPIX));
    checkOutput("sb_empty", 64'(exp_q.size()), 64'd0);
    checkOutput("idle_busy", 64'(busy), 64'd0);
    checkOutput("checksum", 64'(checksum), 64'(exp_sum));
  endtask

  initial begin
    logic [31:0] sum4;

    xrst       = 1'b0;
    start      = 1'b0;
    pixel_in   = 24'h0;
    rcv_ack    = 1'b0;
    out_ready  = 1'b0;
    start2     = 1'b0;
    pixel_in2  = 24'h0;
    rcv_ack2   = 1'b0;
    out_ready2 = 1'b0;
    for (int i = 0; i < NPIX; i++) frame_px[i] = 24'(i + 1);

    // Power-on reset state.
    repeat (2) tick();
    checkOutput("rst_req", 64'(rcv_req), 64'd0);
    checkOutput("rst_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_pixel", 64'(out_pixel), 64'd0);
    checkOutput("rst_flags", 64'({out_sof, out_eol, out_eof}), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_checksum", 64'(checksum), 64'd0);
    xrst = 1'b1;
    tick();

    // Reset mid-frame with three pixels buffered.
    pix_idx    = 0;
    xfers      = 0;
    done_cnt   = 0;
    exp_q.delete();
    ack_mode   = 0;
    ready_mode = 2;
    rcv_ack    = 1'b1;
    out_ready  = 1'b0;
    pixel_in   = frame_px[0];
    start      = 1'b1;
    repeat (4) tick();
    checkOutput("mid_xfers", 64'(xfers), 64'd3);
    checkOutput("mid_valid", 64'(out_valid), 64'd1);
    xrst = 1'b0;
    tick();
    checkOutput("midrst_req", 64'(rcv_req), 64'd0);
    checkOutput("midrst_valid", 64'(out_valid), 64'd0);
    checkOutput("midrst_pixel", 64'(out_pixel), 64'd0);
    checkOutput("midrst_flags", 64'({out_sof, out_eol, out_eof}), 64'd0);
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    checkOutput("midrst_checksum", 64'(checksum), 64'd0);
    xrst = 1'b1;
    exp_q.delete();
    ack_mode = 2;
    repeat (4) tick();
    checkOutput("midrst_no_done", 64'(done_cnt), 64'd0);

    // Full-rate frame, pixels 1..8.
    applyStimulus(0, 0, 0, 1'b0, 32'd36, 10);

    // Sink stalled for ten cycles, then drains.
    applyStimulus(0, 0, 10, 1'b0, 32'd36, 0);

    // Toggling ack with random backpressure.
    frame_px[0] = 24'h0A0B0C; frame_px[1] = 24'h112233;
    frame_px[2] = 24'h445566; frame_px[3] = 24'h778899;
    frame_px[4] = 24'hAABBCC; frame_px[5] = 24'hDDEEFF;
    frame_px[6] = 24'h010203; frame_px[7] = 24'hFEDCBA;
    sum4 = 32'h0;
    for (int i = 0; i < NPIX; i++) sum4 = sum4 + {8'h00, frame_px[i]};
    applyStimulus(1, 1, 0, 1'b0, sum4, 0);

    // All-ones pixels with start pokes while busy.
    for (int i = 0; i < NPIX; i++) frame_px[i] = 24'hFFFFFF;
    applyStimulus(0, 1, 0, 1'b1, 32'h07FFFFF8, 0);

    // 2x1 frame on the second instance.
    out_ready2 = 1'b0;
    rcv_ack2   = 1'b1;
    pixel_in2  = 24'h0000A1;
    start2     = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    checkOutput("g2_req_run", 64'(rcv_req2), 64'd1);
    @(posedge clk); #1;
    pixel_in2 = 24'h0000B2;
    @(posedge clk); #1;
    checkOutput("g2_req_flush", 64'(rcv_req2), 64'd0);
    checkOutput("g2_head0", 64'({out_valid2, out_pixel2, out_sof2, out_eol2, out_eof2}),
                64'({1'b1, 24'h0000A1, 3'b100}));
    out_ready2 = 1'b1;
    @(posedge clk); #1;
    checkOutput("g2_head1", 64'({out_valid2, out_pixel2, out_sof2, out_eol2, out_eof2}),
                64'({1'b1, 24'h0000B2, 3'b011}));
    @(posedge clk); #1;
    checkOutput("g2_done", 64'({done2, out_valid2}), 64'(2'b10));
    @(posedge clk); #1;
    checkOutput("g2_idle", 64'({done2, busy2}), 64'd0);
    checkOutput("g2_checksum", 64'(checksum2), 64'h153);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
